// File: rtl/sync_debounce.sv
// sync_debounce: per-channel DEPTH-flop synchronizer followed by a stability
// debouncer. Define SYNC_DEBOUNCE_EDGE_EN to generate rise/fall pulses.
module sync_debounce #(
  parameter int               WIDTH         = 1,
  parameter int               DEPTH         = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] sync_d [DEPTH];
  logic [WIDTH-1:0] synced;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] accept;

  // Shift chain: stage 0 samples the raw inputs, each stage feeds the next.
  always_comb begin
    sync_d[0] = data_in;
    for (int k = 1; k < DEPTH; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Synchronizer flops, forced to the reset value asynchronously.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign synced = sync_q[DEPTH-1];

  // Count consecutive cycles of disagreement; any agreement drops the count.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != out_q[i]) begin
        if (cnt_q[i] == LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  // Accepted channels take the synchronized level, others hold.
  always_comb begin
    out_d = (out_q & ~accept) | (synced & accept);
  end

  // Debounce state: per-channel counters and the accepted levels.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_q <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_out = out_q;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  // An acceptance always flips the level, so its direction is the new value.
  always_comb begin
    rise_d = accept & synced;
    fall_d = accept & ~synced;
  end

  // One-cycle registered edge pulses; reset never produces a pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_out = rise_q;
  assign fall_out = fall_q;
`else
  assign rise_out = '0;
  assign fall_out = '0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: vector table, directed corner cases and random stimulus
// against a sample-history reference model.
`timescale 1ns/1ps
module tb_sync_debounce;

  localparam int W = 4;
  localparam int D = 2;
  localparam int S = 4;
  localparam logic [3:0] R = 4'b1010;
`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam logic [3:0] EM = 4'hF;
`else
  localparam logic [3:0] EM = 4'h0;
`endif

  logic       clk_in   = 1'b0;
  logic       clk_run  = 1'b0;
  logic       rst_n_in = 1'b1;
  logic [3:0] data_in  = R;
  logic [3:0] data_out;
  logic [3:0] rise_out;
  logic [3:0] fall_out;

  int checks = 0;
  int errors = 0;

  sync_debounce #(
    .WIDTH(W),
    .DEPTH(D),
    .STABLE_CYCLES(S),
    .RESET_VAL(R)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .data_in(data_in),
    .data_out(data_out),
    .rise_out(rise_out),
    .fall_out(fall_out)
  );

  always #5 if (clk_run) clk_in = ~clk_in;

  // Reference: pipe holds samples still in flight, hist the last S
  // synchronized samples seen since reset.
  logic [3:0] pipe [$];
  logic [3:0] hist [$];
  logic [3:0] m_out;
  logic [3:0] m_rise;
  logic [3:0] m_fall;

  task automatic m_reset();
    pipe.delete();
    for (int k = 0; k < D; k++) pipe.push_back(R);
    hist.delete();
    m_out  = R;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic m_edge(input logic [3:0] din);
    logic [3:0] syn;
    logic [3:0] acc;
    bit         all;
    syn = pipe.pop_front();
    pipe.push_back(din);
    hist.push_back(syn);
    if (hist.size() > S) void'(hist.pop_front());
    acc = '0;
    for (int i = 0; i < W; i++) begin
      all = (hist.size() == S);
      foreach (hist[j]) if (hist[j][i] == m_out[i]) all = 0;
      acc[i] = all;
    end
    m_rise = acc & ~m_out;
    m_fall = acc & m_out;
    m_out  = m_out ^ acc;
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] din);
    data_in = din;
    @(posedge clk_in);
    if (rst_n_in) m_edge(din);
    @(negedge clk_in);
    chk("model data_out", data_out, m_out);
    chk("model rise_out", rise_out, m_rise & EM);
    chk("model fall_out", fall_out, m_fall & EM);
  endtask

  task automatic pulse_reset();
    #2 rst_n_in = 1'b0;
    #1;
    m_reset();
    chk("async rst data_out", data_out, R);
    chk("async rst rise_out", rise_out, 4'h0);
    chk("async rst fall_out", fall_out, 4'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  typedef struct {
    logic [3:0] din;
    int         reps;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int         nr;
    logic [3:0] flip;

    tbl[0] = '{4'b1011, 5, 4'b1010, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1011, 1, 4'b1011, 4'b0001, 4'b0000};
    tbl[2] = '{4'b1011, 1, 4'b1011, 4'b0000, 4'b0000};
    tbl[3] = '{4'b1010, 3, 4'b1011, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1011, 5, 4'b1011, 4'b0000, 4'b0000};
    tbl[5] = '{4'b1010, 5, 4'b1011, 4'b0000, 4'b0000};
    tbl[6] = '{4'b1010, 1, 4'b1010, 4'b0000, 4'b0001};
    tbl[7] = '{4'b1010, 1, 4'b1010, 4'b0000, 4'b0000};

    // Reset with the clock stopped must act immediately.
    #1 rst_n_in = 1'b0;
    #1;
    m_reset();
    chk("stopped-clk rst data_out", data_out, R);
    chk("stopped-clk rst rise_out", rise_out, 4'h0);
    chk("stopped-clk rst fall_out", fall_out, 4'h0);
    clk_run = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Latency, glitch rejection and fall, from the vector table.
    foreach (tbl[v]) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].din);
        chk("tbl data_out", data_out, tbl[v].dout);
        chk("tbl rise_out", rise_out, tbl[v].rise & EM);
        chk("tbl fall_out", fall_out, tbl[v].fall & EM);
      end
    end

    // A pulse exactly S cycles wide is accepted once.
    nr = 0;
    for (int k = 0; k < 14; k++) begin
      step(k < 4 ? 4'b1011 : 4'b1010);
      if (rise_out[0]) nr++;
    end
    chk("pulse4 rise count", 4'(nr), {3'b000, EM[0]});
    chk("pulse4 final level", data_out, 4'b1010);

    // Two channels changing two cycles apart are accepted two cycles apart.
    for (int k = 0; k < 10; k++) begin
      step(k < 2 ? 4'b1011 : 4'b1111);
      if (k == 4) chk("indep before ch0", data_out, 4'b1010);
      if (k == 5) chk("indep ch0 accepted", data_out, 4'b1011);
      if (k == 6) chk("indep ch2 pending", data_out, 4'b1011);
      if (k == 7) chk("indep ch2 accepted", data_out, 4'b1111);
    end
    for (int k = 0; k < 8; k++) step(4'b1010);

    // Reset mid-count discards progress; full latency needed again.
    for (int k = 0; k < 4; k++) step(4'b1011);
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'b1011);
      if (k == 4) chk("post-rst still held", data_out, R);
      if (k == 5) chk("post-rst accepted", data_out, 4'b1011);
    end

    // Random sparse toggling with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      flip = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(data_in ^ flip);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
